fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter that shares one 8-bit synchronous FIFO write port between N_REQ producers.
- Grants one producer at a time and holds the grant for a packet, up to MAX_BURST beats, then rotates fairly.
- Sits directly in front of the FIFO write port. It drives wr_en/data and consumes full.
- A beat is never written into a full FIFO.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// A granted producer keeps the port for one packet (up to MAX_BURST beats),
// then the pointer rotates past it. Writes are gated by the FIFO full flag
// in the same cycle, so a beat is never pushed into a full FIFO.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int OWNER_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic [N_REQ-1:0]        last_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic                    fifo_wr_en_o,
  output logic [DATA_W-1:0]       fifo_data_o,
  input  logic                    fifo_full_i,
  output logic                    busy_o,
  output logic [OWNER_W-1:0]      owner_o
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [2*N_REQ-1:0]   req_dbl;
  logic [N_REQ-1:0]     req_rot;
  logic                 win_found;
  logic [OWNER_W-1:0]   win_idx;
  logic                 beat;
  logic                 at_cap;
  logic                 release_now;

  // Rotate the request vector so bit 0 is the producer at rr_ptr.
  assign req_dbl = {req_i, req_i} >> rr_ptr_q;
  assign req_rot = req_dbl[N_REQ-1:0];

  // Pick the first requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = 0;
    // Scan downwards so the lowest rotated index is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sum = int'(rr_ptr_q) + i;
        if (sum >= N_REQ) sum = sum - N_REQ;
        win_found = 1'b1;
        win_idx   = OWNER_W'(sum);
      end
    end
  end

  // A beat moves only when the owner is offering data and the FIFO has room.
  assign beat        = (state_q == OWN) & req_i[owner_q] & ~fifo_full_i;
  assign at_cap      = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_now = beat & (last_i[owner_q] | at_cap);

  // Write path and status outputs; data is steered from the owner even when idle.
  always_comb begin
    gnt_o = '0;
    if (state_q == OWN) gnt_o[owner_q] = 1'b1;
  end

  assign fifo_wr_en_o = beat;
  assign fifo_data_o  = data_i[owner_q*DATA_W +: DATA_W];
  assign busy_o       = (state_q == OWN);
  assign owner_o      = owner_q;

  // Next-state logic: grant from IDLE, count beats and release from OWN.
  always_comb begin
    // NOTE: every variable gets a default here, otherwise paths that skip an
    // assignment would infer a latch.
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = OWN;
          owner_d    = win_idx;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        if (release_now) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == OWNER_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any grant immediately and abandons the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by a
// randomized phase, all predicted by a packet-level reference model with
// per-producer beat queues acting as the scoreboard for FIFO write order.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    last_i;
  logic [N-1:0]    gnt_o;
  logic            fifo_wr_en_o;
  logic [DW-1:0]   fifo_data_o;
  logic            fifo_full_i;
  logic            busy_o;
  logic [OW-1:0]   owner_o;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .MAX_BURST(MB),
    .OWNER_W  (OW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .last_i      (last_i),
    .gnt_o       (gnt_o),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_data_o (fifo_data_o),
    .fifo_full_i (fifo_full_i),
    .busy_o      (busy_o),
    .owner_o     (owner_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Per-producer pending beats: {last, data}. Head is what the producer offers.
  logic [8:0] pq [N][$];
  int         seq [N];

  // Reference model: who owns the port, beats granted so far, rotation start.
  bit m_own;
  int m_owner;
  int m_cnt;
  int m_ptr;

  int         beat_log [$];
  logic [N-1:0] obs_gnt;
  logic         obs_wr;
  logic [DW-1:0] obs_data;

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
  endtask

  task automatic push_beat(input int k, input logic [7:0] d, input bit last);
    pq[k].push_back({last, d});
  endtask

  task automatic push_pkt(input int k, input int len, input bit with_last);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = {k[1:0], seq[k][5:0]};
      seq[k]++;
      push_beat(k, d, with_last && (b == len - 1));
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < N; k++) n += pq[k].size();
    return n;
  endfunction

  // One clock cycle: drive producers at the falling edge, compare, advance model.
  task automatic step(input bit full, input logic [N-1:0] stall);
    logic [N-1:0] exp_gnt;
    bit           exp_wr;
    int           c;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (pq[k].size() > 0 && !stall[k]) begin
        req_i[k]           = 1'b1;
        data_i[k*DW +: DW] = pq[k][0][7:0];
        last_i[k]          = pq[k][0][8];
      end else begin
        req_i[k]           = 1'b0;
        data_i[k*DW +: DW] = 8'($urandom);
        last_i[k]          = 1'($urandom);
      end
    end
    fifo_full_i = full;
    #1;
    exp_gnt = m_own ? (N'(1) << m_owner) : '0;
    exp_wr  = m_own && req_i[m_owner] && !full;
    check("gnt", gnt_o, exp_gnt);
    check("wr_en", fifo_wr_en_o, exp_wr);
    check("busy", busy_o, m_own);
    check("owner", owner_o, m_owner);
    check("data_slice", fifo_data_o, data_i[m_owner*DW +: DW]);
    obs_gnt  = gnt_o;
    obs_wr   = fifo_wr_en_o;
    obs_data = fifo_data_o;
    if (exp_wr) begin
      check("fifo_order", fifo_data_o, pq[m_owner][0][7:0]);
      beat_log.push_back(m_owner);
      m_cnt++;
      if (pq[m_owner][0][8] || m_cnt == MB) begin
        m_own = 0;
        m_ptr = (m_owner + 1) % N;
      end
      void'(pq[m_owner].pop_front());
    end else if (!m_own) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (req_i[c]) begin
          m_own = 1; m_owner = c; m_cnt = 0;
          break;
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while ((pending() > 0 || m_own) && budget < 400) begin
      step(1'b0, '0);
      budget++;
    end
    check({tag, "_drain_timeout"}, budget < 400, 1);
  endtask

  task automatic wait_beats(input string tag, input int n);
    int budget = 0;
    while (beat_log.size() < n && budget < 200) begin
      step(1'b0, '0);
      budget++;
    end
    check({tag, "_beat_timeout"}, beat_log.size() >= n, 1);
  endtask

  int exp_burst [10] = '{2, 2, 2, 2, 3, 3, 2, 2, 2, 0};

  initial begin
    rst_n = 1'b0;
    req_i = '0; data_i = '0; last_i = '0; fifo_full_i = 1'b0;
    for (int k = 0; k < N; k++) seq[k] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_wr_en", fifo_wr_en_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_owner", owner_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single producer, three beats, last on the third.
    push_beat(1, 8'hA1, 0);
    push_beat(1, 8'hA2, 0);
    push_beat(1, 8'hA3, 1);
    step(1'b0, '0);
    check("single_c0_gnt", obs_gnt, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0);
      check("single_gnt", obs_gnt, 4'b0010);
      check("single_wr", obs_wr, 1);
      check("single_data", obs_data, 8'hA1 + i);
    end
    step(1'b0, '0);
    check("single_idle_gnt", obs_gnt, 4'b0000);
    // Pointer now at 2: producers 0 and 3 compete, 3 must win.
    push_pkt(0, 1, 1);
    push_pkt(3, 1, 1);
    beat_log.delete();
    wait_beats("ptr2", 1);
    check("ptr2_winner", beat_log[0], 3);
    drain("single");

    // Fairness: every producer keeps offering single-beat packets.
    beat_log.delete();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < N; k++) push_pkt(k, 1, 1);
    drain("fair");
    check("fair_count", beat_log.size(), 12);
    for (int i = 1; i < beat_log.size(); i++)
      check("fair_order", beat_log[i], (beat_log[i-1] + 1) % N);

    // Burst cap, then owner stall while another producer is waiting.
    beat_log.delete();
    push_pkt(2, 6, 0);
    push_pkt(3, 2, 1);
    wait_beats("burst", 8);
    push_pkt(0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0);
      check("stall_gnt", obs_gnt, 4'b0100);
      check("stall_wr", obs_wr, 0);
    end
    push_pkt(2, 1, 1);
    drain("burst");
    check("burst_count", beat_log.size(), 10);
    for (int i = 0; i < 10 && i < beat_log.size(); i++)
      check("burst_order", beat_log[i], exp_burst[i]);

    // FIFO full for three cycles in the middle of a packet.
    beat_log.delete();
    push_pkt(1, 4, 1);
    wait_beats("full", 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, '0);
      check("full_wr", obs_wr, 0);
      check("full_gnt", obs_gnt, 4'b0010);
    end
    drain("full");
    check("full_count", beat_log.size(), 4);

    // Asynchronous reset after two of four beats.
    beat_log.delete();
    push_pkt(2, 4, 1);
    wait_beats("arst", 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt_o, 0);
    check("arst_wr_en", fifo_wr_en_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_owner", owner_o, 0);
    req_i = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(1, 1, 1);
    push_pkt(3, 1, 1);
    step(1'b0, '0);
    check("arst_idle_gnt", obs_gnt, 4'b0000);
    step(1'b0, '0);
    check("arst_first_gnt", obs_gnt, 4'b0010);
    drain("arst");

    // Randomized traffic with stalls and back-pressure.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int k;
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, N - 1);
        if (pq[k].size() < 12)
          push_pkt(k, $urandom_range(1, 6), $urandom_range(0, 3) != 0);
      end
      step($urandom_range(0, 5) == 0, N'($urandom) & N'($urandom));
    end
    for (int k = 0; k < N; k++) push_pkt(k, 1, 1);
    drain("random");
    check("all_drained", pending(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
